pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded at reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000000: instruction word presented to decode when IFID_Valid=0.
REQ-003 Port Clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1: synchronous, active-high reset.
REQ-005 Port PCSrc, input, 2: branch-resolution select; 1 = redirect, any other value = sequential.
REQ-006 Port PCNew, input, 32: redirect target, meaningful only when PCSrc=1.
REQ-007 Port Stall, input, 1: hazard hold from decode; IF/ID must not change while high, except on flush.
REQ-008 Port IMemReq, output, 1: instruction-memory request valid.
REQ-009 Port IMemAddr, output, 32: fetch address, word aligned.
REQ-010 Port IMemReady, input, 1: IMemData valid this cycle; completes the outstanding request.
REQ-011 Port IMemData, input, 32: fetched instruction.
REQ-012 Port PC, output, 32: current fetch PC.
REQ-013 Ports IFID_Instr (output, 32), IFID_PCPlus4 (output, 32) and IFID_Valid (output, 1): registered IF/ID stage contents.

Function
REQ-014 States SHALL be REQ (request outstanding), HOLD (instruction buffered under Stall) and DRAIN (stale request outstanding after a redirect).
REQ-015 In REQ and DRAIN, IMemReq=1; in HOLD, IMemReq=0.
REQ-016 IMemAddr SHALL equal PC and SHALL be stable from request issue until IMemReady.
REQ-017 Redirect = (PCSrc==1); it has priority over Stall.
REQ-018 Redirect handling SHALL be: load {PCNew[31:2],2'b00} as the new PC; set IFID_Valid=0 and IFID_Instr=NOP_INSTR in the same edge.
REQ-019 REQ, IMemReady=1, no redirect, Stall=0: load IF/ID with {IMemData, PC+4, Valid=1}; PC<=PC+4; remain in REQ. This gives one-cycle fetch latency when memory is zero-wait.
REQ-020 REQ, IMemReady=1, no redirect, Stall=1: capture IMemData into the hold buffer; go to HOLD; IF/ID unchanged.
REQ-021 REQ, IMemReady=0, no redirect: Stall=1 keeps IF/ID unchanged; Stall=0 inserts a bubble (IFID_Valid=0).
REQ-022 REQ with redirect: if IMemReady=1, discard the data, apply the new PC and stay in REQ; if IMemReady=0, latch the target in PendingPC and go to DRAIN.
REQ-023 HOLD, no redirect: Stall=1 holds everything; Stall=0 loads IF/ID from the buffer, sets PC<=PC+4 and goes to REQ.
REQ-024 HOLD with redirect: discard the buffer, flush IF/ID, apply the new PC and go to REQ.
REQ-025 DRAIN: IMemAddr holds the stale PC; on IMemReady the data is discarded, PC<=PendingPC and the state goes to REQ.
REQ-026 A redirect while in DRAIN SHALL overwrite PendingPC.
REQ-027 IF/ID SHALL be a bubble while in DRAIN unless Stall=1.
REQ-028 PC+4 wraps modulo 2^32 (32'hFFFFFFFC+4 = 0); no overflow flag.
REQ-029 Returned data SHALL never be written to IF/ID with a PC other than the address it was fetched from.

Reset
REQ-030 When Reset=1 at an edge, the following SHALL apply, overriding all other inputs: PC=RESET_PC, state=REQ, PendingPC=0, hold buffer=0, IFID_Valid=0, IFID_Instr=NOP_INSTR, IFID_PCPlus4=0.
REQ-031 Reset mid-request (REQ or DRAIN) SHALL abandon the outstanding request; the next IMemReady SHALL be treated as the response for RESET_PC.
REQ-032 The first request (IMemReq=1, IMemAddr=RESET_PC) SHALL be issued in the cycle after Reset deasserts.

Structure
REQ-033 A shared package SHALL hold the state encoding, the PCSrc codes (PCSRC_SEQ=0, PCSRC_REDIRECT=1) and the default NOP constant.
REQ-034 The IF/ID register with load/hold/flush SHALL be one sub-module, ifid_reg; the FSM and PC logic stay in pc_fetch_unit.

Verification
REQ-035 Zero-wait stream, IMemReady=1, RESET_PC=0: IMemAddr 0,4,8 on consecutive cycles; IFID_PCPlus4 4,8,12 with Valid=1.
REQ-036 Stall=1 for 3 cycles, with data 0xAABBCCDD returning on the first: state HOLD, IF/ID frozen; after release IFID_Instr=0xAABBCCDD, PC advances by 4.
REQ-037 Redirect PCSrc=1, PCNew=0x00000103 while IMemReady=0: state DRAIN; stale data discarded; next IMemAddr=0x00000100; IFID_Valid=0 throughout.
REQ-038 Redirect and Stall both asserted in HOLD: buffer discarded, IF/ID flushed, PC=PCNew.
REQ-039 PC=0xFFFFFFFC, fetch completes: PC=0x00000000, IFID_PCPlus4=0x00000000.
REQ-040 Reset asserted in DRAIN: next cycle IMemAddr=RESET_PC, IFID_Valid=0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// PCSrc select codes, the default NOP word and small PC helpers.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  PCSRC_SEQ      = 2'd0;
  localparam logic [1:0]  PCSRC_REDIRECT = 2'd1;
  localparam logic [31:0] NOP_DEFAULT    = 32'h0000_0000;

  // Sequential PC advance; wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Force a target address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_ifid.sv
// IF/ID pipeline register: load a new instruction, flush to a bubble,
// or hold its contents. Flush wins over load.
module ifid_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pcplus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  // Select next IF/ID contents: flush -> bubble, load -> new entry, else hold.
  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d   = instr_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end
  end

  // Register IF/ID with synchronous reset to an empty bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: owns the PC, a single outstanding instruction
// memory request, a one-entry hold buffer for stalls and redirect draining.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCNew,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  hold_buf_q, hold_buf_d;
  logic         imem_req_q, imem_req_d;

  logic         ifid_load, ifid_flush;
  logic [31:0]  ifid_instr_in;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  assign redirect = (PCSrc == PCSRC_REDIRECT);
  assign target   = word_align(PCNew);
  assign pc_plus4 = pc_inc(pc_q);

  // Next-state, PC and IF/ID control. The PC register doubles as the
  // fetch address, so it only moves when the outstanding request completes
  // (or when nothing is outstanding), keeping IMemAddr stable meanwhile.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    hold_buf_d    = hold_buf_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr_in = IMemData;

    unique case (state_q)
      ST_REQ: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          if (IMemReady) begin
            pc_d = target;
          end else begin
            pending_pc_d = target;
            state_d      = ST_DRAIN;
          end
        end else if (IMemReady) begin
          if (!Stall) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
          end else begin
            hold_buf_d = IMemData;
            state_d    = ST_HOLD;
          end
        end else if (!Stall) begin
          ifid_flush = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          state_d    = ST_REQ;
        end else if (!Stall) begin
          ifid_load     = 1'b1;
          ifid_instr_in = hold_buf_q;
          pc_d          = pc_plus4;
          state_d       = ST_REQ;
        end
      end

      ST_DRAIN: begin
        // The stale response is thrown away; the newest target wins.
        if (redirect) begin
          pending_pc_d = target;
        end
        ifid_flush = redirect || !Stall;
        if (IMemReady) begin
          pc_d    = redirect ? target : pending_pc_q;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase

    imem_req_d = (state_d != ST_HOLD);
  end

  // FSM and PC registers; reset abandons any outstanding request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      pending_pc_q <= 32'h0;
      hold_buf_q   <= 32'h0;
      imem_req_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      hold_buf_q   <= hold_buf_d;
      imem_req_q   <= imem_req_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk       (Clk),
    .rst       (Reset),
    .load_i    (ifid_load),
    .flush_i   (ifid_flush),
    .instr_i   (ifid_instr_in),
    .pcplus4_i (pc_plus4),
    .instr_o   (IFID_Instr),
    .pcplus4_o (IFID_PCPlus4),
    .valid_o   (IFID_Valid)
  );

  assign IMemReq  = imem_req_q;
  assign IMemAddr = pc_q;
  assign PC       = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  PCSrc;
  logic [31:0] PCNew;
  logic        Stall;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] PC;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model of what the fetch unit must present.
  logic [31:0] m_pc, m_pend, m_buf;
  bit          m_has_buf, m_stale;
  logic        m_valid;
  logic [31:0] m_instr, m_pcp4;

  pc_fetch_unit #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCSrc        (PCSrc),
    .PCNew        (PCNew),
    .Stall        (Stall),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemReady    (IMemReady),
    .IMemData     (IMemData),
    .PC           (PC),
    .IFID_Instr   (IFID_Instr),
    .IFID_PCPlus4 (IFID_PCPlus4),
    .IFID_Valid   (IFID_Valid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bubble();
    m_valid = 1'b0;
    m_instr = NOP;
  endtask

  task automatic deliver(input logic [31:0] instr, input logic [31:0] addr);
    m_valid = 1'b1;
    m_instr = instr;
    m_pcp4  = addr + 32'd4;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic rst, input logic [1:0] src, input logic [31:0] nw,
                            input logic st, input logic rdy, input logic [31:0] dat);
    bit          redir;
    logic [31:0] tgt;
    redir = (src == 2'd1);
    tgt   = {nw[31:2], 2'b00};
    if (rst) begin
      m_pc = RST_PC; m_pend = 0; m_buf = 0; m_has_buf = 0; m_stale = 0;
      m_valid = 0; m_instr = NOP; m_pcp4 = 0;
    end else if (m_has_buf) begin
      if (redir) begin
        bubble(); m_pc = tgt; m_has_buf = 0;
      end else if (!st) begin
        deliver(m_buf, m_pc); m_pc = m_pc + 4; m_has_buf = 0;
      end
    end else if (m_stale) begin
      if (redir) m_pend = tgt;
      if (redir || !st) bubble();
      if (rdy) begin
        m_pc = m_pend; m_stale = 0;
      end
    end else begin
      if (redir) begin
        bubble();
        if (rdy) m_pc = tgt;
        else begin m_pend = tgt; m_stale = 1; end
      end else if (rdy) begin
        if (!st) begin deliver(dat, m_pc); m_pc = m_pc + 4; end
        else begin m_buf = dat; m_has_buf = 1; end
      end else if (!st) begin
        bubble();
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic [1:0] src, input logic [31:0] nw,
                     input logic st, input logic rdy, input logic [31:0] dat);
    Reset = rst; PCSrc = src; PCNew = nw; Stall = st; IMemReady = rdy; IMemData = dat;
    @(posedge Clk);
    model_edge(rst, src, nw, st, rdy, dat);
    #1;
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("imem_req",  {31'b0, IMemReq},   {31'b0, !m_has_buf});
      chk("imem_addr", IMemAddr,           m_pc);
      chk("pc",        PC,                 m_pc);
      chk("ifid_vld",  {31'b0, IFID_Valid}, {31'b0, m_valid});
      chk("ifid_ins",  IFID_Instr,         m_instr);
      chk("ifid_pcp4", IFID_PCPlus4,       m_pcp4);
    end
  end

  initial begin
    logic        rdy, st, rst;
    logic [1:0]  src;
    logic [31:0] nw;

    Reset = 1; PCSrc = 0; PCNew = 0; Stall = 0; IMemReady = 0; IMemData = 0;
    cyc(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    cyc(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk_en = 1'b1;

    // Reset state
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", {31'b0, IMemReq}, 32'h1);
    chk("rst_vld", {31'b0, IFID_Valid}, 32'h0);
    chk("rst_ins", IFID_Instr, NOP);
    chk("rst_pcp4", IFID_PCPlus4, 32'h0);

    // Zero-wait stream
    chk("strm_a0", IMemAddr, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h1000_0000);
    chk("strm_p4", IFID_PCPlus4, 32'h4);
    chk("strm_a1", IMemAddr, 32'h4);
    cyc(0, 0, 0, 0, 1, 32'h1000_0004);
    chk("strm_p8", IFID_PCPlus4, 32'h8);
    chk("strm_a2", IMemAddr, 32'h8);
    cyc(0, 0, 0, 0, 1, 32'h1000_0008);
    chk("strm_p12", IFID_PCPlus4, 32'hC);
    chk("strm_i12", IFID_Instr, 32'h1000_0008);
    chk("strm_v", {31'b0, IFID_Valid}, 32'h1);

    // Stall three cycles, data returns on the first
    cyc(0, 0, 0, 1, 1, 32'hAABB_CCDD);
    cyc(0, 0, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 1, 0, 32'h0);
    chk("hold_req", {31'b0, IMemReq}, 32'h0);
    chk("hold_pcp4", IFID_PCPlus4, 32'hC);
    chk("hold_ins", IFID_Instr, 32'h1000_0008);
    chk("hold_pc", PC, 32'hC);
    cyc(0, 0, 0, 0, 0, 32'h0);
    chk("rel_ins", IFID_Instr, 32'hAABB_CCDD);
    chk("rel_pcp4", IFID_PCPlus4, 32'h10);
    chk("rel_pc", PC, 32'h10);

    // Redirect while memory is busy: drain the stale response
    cyc(0, 1, 32'h0000_0103, 0, 0, 32'h0);
    chk("drn_addr", IMemAddr, 32'h10);
    chk("drn_vld", {31'b0, IFID_Valid}, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'hBAD0_0010);
    chk("drn_new", IMemAddr, 32'h100);
    chk("drn_vld2", {31'b0, IFID_Valid}, 32'h0);
    chk("drn_ins", IFID_Instr, NOP);

    // Redirect together with stall while holding
    cyc(0, 0, 0, 1, 1, 32'h1111_1111);
    cyc(0, 1, 32'h0000_0200, 1, 0, 32'h0);
    chk("hr_pc", PC, 32'h200);
    chk("hr_vld", {31'b0, IFID_Valid}, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h2222_2222);
    chk("hr_ins", IFID_Instr, 32'h2222_2222);
    chk("hr_pcp4", IFID_PCPlus4, 32'h204);

    // PC wrap
    cyc(0, 1, 32'hFFFF_FFFF, 0, 1, 32'hBAD0_0204);
    chk("wr_pc0", PC, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 32'h3333_3333);
    chk("wr_pc", PC, 32'h0);
    chk("wr_pcp4", IFID_PCPlus4, 32'h0);
    chk("wr_vld", {31'b0, IFID_Valid}, 32'h1);

    // Reset while draining
    cyc(0, 0, 0, 0, 1, 32'h5555_5555);
    cyc(0, 1, 32'h0000_0400, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0);
    chk("rd_addr", IMemAddr, RST_PC);
    chk("rd_vld", {31'b0, IFID_Valid}, 32'h0);
    chk("rd_req", {31'b0, IMemReq}, 32'h1);
    cyc(0, 0, 0, 0, 1, 32'h4444_4444);
    chk("rd_ins", IFID_Instr, 32'h4444_4444);
    chk("rd_pcp4", IFID_PCPlus4, 32'h4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      src = ($urandom_range(0, 4) == 0) ? 2'd1 : 2'($urandom_range(0, 3) & 2'd2);
      if ($urandom_range(0, 15) == 0) src = 2'd3;
      nw  = $urandom;
      st  = ($urandom_range(0, 9) < 3);
      rdy = !m_has_buf && ($urandom_range(0, 1) == 1);
      cyc(rst, src, nw, st, rdy, $urandom);
    end

    @(negedge Clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
